// File: rtl/nco_phase_accumulator_if.sv
// Control/observation bundle for the NCO phase accumulator: tuning-word load
// path from the SPI latch and the oscillator outputs to the voice stage.
interface nco_phase_accumulator_if #(
    parameter int SAW_WIDTH = 8
);
    logic [31:0]          i_tuning_word;
    logic                 i_word_strobe;
    logic                 i_sync;
    logic                 o_square;
    logic [SAW_WIDTH-1:0] o_saw;
    logic                 o_wrap;
    logic                 o_pending;

    modport master (
        output i_tuning_word,
        output i_word_strobe,
        output i_sync,
        input  o_square,
        input  o_saw,
        input  o_wrap,
        input  o_pending
    );

    modport slave (
        input  i_tuning_word,
        input  i_word_strobe,
        input  i_sync,
        output o_square,
        output o_saw,
        output o_wrap,
        output o_pending
    );
endinterface

// File: rtl/nco_phase_accumulator.sv
// Phase-accumulator oscillator with prescaled ticks, hard sync and glitch-free
// tuning-word updates (immediate or deferred to the next phase wrap).
module nco_phase_accumulator #(
    parameter int SAW_WIDTH      = 8,
    parameter int PRESCALE       = 1,
    parameter int UPDATE_AT_WRAP = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    nco_phase_accumulator_if.slave bus
);

    localparam logic [15:0] TICK_LAST = 16'(PRESCALE - 1);
    localparam bit          IMMEDIATE = (UPDATE_AT_WRAP == 0);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] inc_q, inc_d;
    logic [31:0] shadow_q, shadow_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wrap_q, wrap_d;

    logic        tick;
    logic [32:0] sum;
    logic        carry;
    logic        wrap_event;
    logic        load_direct;
    logic        pending_out;

    assign tick  = (cnt_q == TICK_LAST);
    assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry = sum[32];

    // Hard sync behaves like a wrap for the purpose of releasing a pending word.
    assign wrap_event  = bus.i_sync | (tick & carry);
    assign load_direct = bus.i_word_strobe &
                         (IMMEDIATE | (state_q == ST_STOPPED) | wrap_event);

    // State register and datapath registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_STOPPED;
            acc_q    <= '0;
            inc_q    <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (load_direct) begin
            state_d = (bus.i_tuning_word != 32'd0) ? ST_RUNNING : ST_STOPPED;
        end else if (bus.i_word_strobe) begin
            state_d = ST_PENDING;
        end else if ((state_q == ST_PENDING) && wrap_event) begin
            state_d = (shadow_q != 32'd0) ? ST_RUNNING : ST_STOPPED;
        end
    end

    // Accumulator, prescaler and increment update; sync discards this cycle's tick.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        inc_d    = inc_q;
        shadow_d = shadow_q;

        if (bus.i_sync) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            acc_d  = sum[31:0];
            cnt_d  = '0;
            wrap_d = carry;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (bus.i_word_strobe) begin
            shadow_d = bus.i_tuning_word;
        end

        if (load_direct) begin
            inc_d = bus.i_tuning_word;
        end else if ((state_q == ST_PENDING) && wrap_event) begin
            inc_d = shadow_q;
        end
    end

    // Output logic
    always_comb begin
        pending_out = 1'b0;
        if (state_q == ST_PENDING) begin
            pending_out = 1'b1;
        end
    end

    assign bus.o_square  = acc_q[31];
    assign bus.o_wrap    = wrap_q;
    assign bus.o_pending = pending_out;

    for (genvar gi = 0; gi < SAW_WIDTH; gi++) begin : g_saw
        assign bus.o_saw[gi] = acc_q[32 - SAW_WIDTH + gi];
    end

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Directed bench for nco_phase_accumulator: three instances cover deferred
// update (PRESCALE=1), prescaled operation (PRESCALE=4) and immediate update.
module tb_nco_phase_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    nco_phase_accumulator_if #(.SAW_WIDTH(8)) ia ();
    nco_phase_accumulator_if #(.SAW_WIDTH(8)) ib ();
    nco_phase_accumulator_if #(.SAW_WIDTH(8)) ic ();

    nco_phase_accumulator #(.SAW_WIDTH(8), .PRESCALE(1), .UPDATE_AT_WRAP(1)) ua (
        .i_clock(clk), .i_reset_n(rst_n), .bus(ia.slave));
    nco_phase_accumulator #(.SAW_WIDTH(8), .PRESCALE(4), .UPDATE_AT_WRAP(1)) ub (
        .i_clock(clk), .i_reset_n(rst_n), .bus(ib.slave));
    nco_phase_accumulator #(.SAW_WIDTH(8), .PRESCALE(1), .UPDATE_AT_WRAP(0)) uc (
        .i_clock(clk), .i_reset_n(rst_n), .bus(ic.slave));

    logic [7:0] t1_saw [0:3] = '{8'h40, 8'h80, 8'hC0, 8'h00};
    logic       t1_sq  [0:3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       t1_wr  [0:3] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] t2_saw [0:3] = '{8'h80, 8'h00, 8'h80, 8'h00};
    logic       t2_wr  [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] saw, input logic sq,
                         input logic wr, input logic pend);
        chk({tag, "_saw"}, 32'(ia.o_saw), 32'(saw));
        chk({tag, "_square"}, 32'(ia.o_square), 32'(sq));
        chk({tag, "_wrap"}, 32'(ia.o_wrap), 32'(wr));
        chk({tag, "_pending"}, 32'(ia.o_pending), 32'(pend));
    endtask

    initial begin
        ia.i_tuning_word = '0; ia.i_word_strobe = 1'b0; ia.i_sync = 1'b0;
        ib.i_tuning_word = '0; ib.i_word_strobe = 1'b0; ib.i_sync = 1'b0;
        ic.i_tuning_word = '0; ic.i_word_strobe = 1'b0; ic.i_sync = 1'b0;

        // reset state
        #1 rst_n = 1'b0;
        #1;
        chk_a("reset_a", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset_b_saw", 32'(ib.o_saw), 32'h0);
        chk("reset_c_pending", 32'(ic.o_pending), 32'h0);
        #11 rst_n = 1'b1;

        // quarter-rate square/saw from STOPPED
        ia.i_tuning_word = 32'h4000_0000; ia.i_word_strobe = 1'b1;
        step();
        ia.i_word_strobe = 1'b0;
        chk_a("t1_load", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk_a($sformatf("t1_step%0d", k), t1_saw[k % 4], t1_sq[k % 4], t1_wr[k % 4], 1'b0);
        end

        // deferred update to 0x8000_0000
        ia.i_tuning_word = 32'h8000_0000; ia.i_word_strobe = 1'b1;
        step();
        ia.i_word_strobe = 1'b0;
        chk_a("t2_strobe", 8'h40, 1'b0, 1'b0, 1'b1);
        step(); chk_a("t2_wait1", 8'h80, 1'b1, 1'b0, 1'b1);
        step(); chk_a("t2_wait2", 8'hC0, 1'b1, 1'b0, 1'b1);
        step(); chk_a("t2_wrap", 8'h00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_a($sformatf("t2_fast%0d", k), t2_saw[k], t2_saw[k][7], t2_wr[k], 1'b0);
        end

        // back to 0x4000_0000, then two strobes while pending: last word wins
        ia.i_tuning_word = 32'h4000_0000; ia.i_word_strobe = 1'b1;
        step();
        ia.i_word_strobe = 1'b0;
        chk_a("t3_pre_strobe", 8'h80, 1'b1, 1'b0, 1'b1);
        step(); chk_a("t3_pre_wrap", 8'h00, 1'b0, 1'b1, 1'b0);
        ia.i_tuning_word = 32'h1000_0000; ia.i_word_strobe = 1'b1;
        step(); chk_a("t3_first", 8'h40, 1'b0, 1'b0, 1'b1);
        ia.i_tuning_word = 32'h2000_0000;
        step();
        ia.i_word_strobe = 1'b0;
        chk_a("t3_second", 8'h80, 1'b1, 1'b0, 1'b1);
        step(); chk_a("t3_hold", 8'hC0, 1'b1, 1'b0, 1'b1);
        step(); chk_a("t3_wrap", 8'h00, 1'b0, 1'b1, 1'b0);
        step(); chk_a("t3_new1", 8'h20, 1'b0, 1'b0, 1'b0);
        step(); chk_a("t3_new2", 8'h40, 1'b0, 1'b0, 1'b0);

        // sync at acc=0xC000_0000 with a word pending
        ia.i_tuning_word = 32'h0800_0000; ia.i_word_strobe = 1'b1;
        step();
        ia.i_word_strobe = 1'b0;
        chk_a("t4_strobe", 8'h60, 1'b0, 1'b0, 1'b1);
        step(); step(); step();
        chk_a("t4_before", 8'hC0, 1'b1, 1'b0, 1'b1);
        ia.i_sync = 1'b1;
        step(); chk_a("t4_sync", 8'h00, 1'b0, 1'b0, 1'b0);
        step(); chk_a("t4_held1", 8'h00, 1'b0, 1'b0, 1'b0);
        step(); chk_a("t4_held2", 8'h00, 1'b0, 1'b0, 1'b0);
        ia.i_sync = 1'b0;
        step(); chk_a("t4_loaded", 8'h08, 1'b0, 1'b0, 1'b0);

        // zero word while running: pending until the wrap, then stopped
        ia.i_tuning_word = 32'h0; ia.i_word_strobe = 1'b1;
        step();
        ia.i_word_strobe = 1'b0;
        chk_a("t5_strobe", 8'h10, 1'b0, 1'b0, 1'b1);
        repeat (29) step();
        chk_a("t5_late", 8'hF8, 1'b1, 1'b0, 1'b1);
        step(); chk_a("t5_wrap", 8'h00, 1'b0, 1'b1, 1'b0);
        step(); chk_a("t5_stopped1", 8'h00, 1'b0, 1'b0, 1'b0);
        step(); chk_a("t5_stopped2", 8'h00, 1'b0, 1'b0, 1'b0);

        // PRESCALE=4: sync aligns the prescaler, strobe loads directly
        ib.i_tuning_word = 32'h8000_0000; ib.i_word_strobe = 1'b1; ib.i_sync = 1'b1;
        step();
        ib.i_word_strobe = 1'b0; ib.i_sync = 1'b0;
        chk("b_sync_saw", 32'(ib.o_saw), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("b_square%0d", k), 32'(ib.o_square), 32'((k / 4) % 2));
            chk($sformatf("b_wrap%0d", k), 32'(ib.o_wrap), 32'(k % 8 == 0));
        end

        // immediate update while running
        ic.i_tuning_word = 32'h4000_0000; ic.i_word_strobe = 1'b1;
        step();
        ic.i_word_strobe = 1'b0;
        step(); chk("c_run_saw", 32'(ic.o_saw), 32'h40);
        ic.i_tuning_word = 32'h1000_0000; ic.i_word_strobe = 1'b1;
        step();
        ic.i_word_strobe = 1'b0;
        chk("c_strobe_saw", 32'(ic.o_saw), 32'h80);
        chk("c_strobe_pending", 32'(ic.o_pending), 32'h0);
        step(); chk("c_new_saw", 32'(ic.o_saw), 32'h90);

        // asynchronous reset mid-run
        ia.i_tuning_word = 32'h4000_0000; ia.i_word_strobe = 1'b1;
        step();
        ia.i_word_strobe = 1'b0;
        step(); step();
        chk_a("t6_running", 8'h80, 1'b1, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk_a("t6_async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_reset_c_saw", 32'(ic.o_saw), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
